// File: rtl/ramulator_req_arbiter.sv
// ramulator_req_arbiter
// Round-robin front end that lets NUM_REQ requesters share one
// ramulator_sv_wrapper. Every accepted request is remembered in an
// address-keyed in-flight table so that wrapper responses, which carry only
// an address, can be steered back to the requester that issued them.

module ramulator_req_arbiter #(
  parameter int NUM_REQ           = 4,
  parameter int MAX_INFLIGHT      = 64,
  parameter int PORT_MAX_INFLIGHT = 16,
  parameter int ADDR_W            = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              init_done,
  input  logic [NUM_REQ-1:0]                up_req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]         up_req_addr,
  input  logic [NUM_REQ-1:0]                up_req_type,
  output logic [NUM_REQ-1:0]                up_req_ready,
  output logic [NUM_REQ-1:0]                up_resp_valid,
  output logic [ADDR_W-1:0]                 up_resp_addr,
  output logic                              mem_req_valid,
  output logic [ADDR_W-1:0]                 mem_req_addr,
  output logic                              mem_req_type,
  output logic [31:0]                       mem_req_source_id,
  input  logic                              mem_req_ready,
  input  logic                              mem_resp_valid,
  input  logic [ADDR_W-1:0]                 mem_resp_addr,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_count,
  output logic                              err_unmatched
);

  localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W  = $clog2(MAX_INFLIGHT + 1);
  localparam int PCNT_W = $clog2(PORT_MAX_INFLIGHT + 1);
  localparam int IDX_W  = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

  // In-flight table: only the valid bits need clearing on reset
  logic [MAX_INFLIGHT-1:0] tbl_valid;
  logic [ADDR_W-1:0]       tbl_addr [MAX_INFLIGHT];
  logic [SRC_W-1:0]        tbl_src  [MAX_INFLIGHT];

  logic [PCNT_W-1:0]       port_cnt [NUM_REQ];
  logic [SRC_W-1:0]        rr_ptr;
  logic [SRC_W-1:0]        out_src;

  logic                    table_full;
  logic                    can_load;
  logic [NUM_REQ-1:0]      hazard;
  logic [NUM_REQ-1:0]      eligible;
  logic                    grant_any;
  logic [SRC_W-1:0]        grant_idx;
  logic [ADDR_W-1:0]       grant_addr;
  logic                    grant_type;
  logic                    up_hs;
  logic                    alloc;
  logic                    free_any;
  logic [IDX_W-1:0]        free_idx;
  logic                    match_any;
  logic [IDX_W-1:0]        match_idx;
  logic [SRC_W-1:0]        match_src;
  logic [NUM_REQ-1:0]      port_inc;
  logic [NUM_REQ-1:0]      port_dec;

  // Fullness comes from the registered count, so a slot freed this cycle
  // only becomes grantable on the next one
  assign table_full = (inflight_count == CNT_W'(MAX_INFLIGHT));
  assign can_load   = !mem_req_valid || mem_req_ready;

  // Address hazard: a requester whose address is already in flight must wait
  // until that entry is freed, which keeps table lookups unique
  always_comb begin
    hazard = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int e = 0; e < MAX_INFLIGHT; e++) begin
        if (tbl_valid[e] && (tbl_addr[e] == up_req_addr[i*ADDR_W +: ADDR_W])) begin
          hazard[i] = 1'b1;
        end
      end
    end
  end

  // Per-requester eligibility from registered state and upstream inputs only
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = up_req_valid[i] && init_done && !table_full &&
                    (port_cnt[i] < PCNT_W'(PORT_MAX_INFLIGHT)) && !hazard[i];
    end
  end

  // Round-robin search starting at the pointer, first eligible port wins
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int cand;
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_any && eligible[cand]) begin
        grant_any = 1'b1;
        grant_idx = SRC_W'(cand);
      end
    end
  end

  assign grant_addr   = up_req_addr[grant_idx*ADDR_W +: ADDR_W];
  assign grant_type   = up_req_type[grant_idx];
  assign up_hs        = grant_any && can_load;
  assign up_req_ready = up_hs ? (NUM_REQ'(1) << grant_idx) : '0;

  // Lowest unused table slot for the next allocation
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int e = 0; e < MAX_INFLIGHT; e++) begin
      if (!free_any && !tbl_valid[e]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(e);
      end
    end
  end

  assign alloc = up_hs && free_any;

  // Response lookup; the hazard block guarantees at most one hit
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    for (int e = 0; e < MAX_INFLIGHT; e++) begin
      if (!match_any && mem_resp_valid && tbl_valid[e] && (tbl_addr[e] == mem_resp_addr)) begin
        match_any = 1'b1;
        match_idx = IDX_W'(e);
      end
    end
  end

  assign match_src = tbl_src[match_idx];

  // Per-port counter steering for allocate and free events
  always_comb begin
    port_inc = '0;
    port_dec = '0;
    for (int p = 0; p < NUM_REQ; p++) begin
      port_inc[p] = alloc && (grant_idx == SRC_W'(p));
      port_dec[p] = match_any && (match_src == SRC_W'(p));
    end
  end

  // Table update: allocation and free always target different slots
  always_ff @(posedge clk) begin
    if (rst) begin
      tbl_valid <= '0;
    end else begin
      if (alloc) begin
        tbl_valid[free_idx] <= 1'b1;
        tbl_addr[free_idx]  <= grant_addr;
        tbl_src[free_idx]   <= grant_idx;
      end
      if (match_any) begin
        tbl_valid[match_idx] <= 1'b0;
      end
    end
  end

  // Occupancy and per-port outstanding counts
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_count <= '0;
      for (int p = 0; p < NUM_REQ; p++) port_cnt[p] <= '0;
    end else begin
      if (alloc && !match_any) begin
        inflight_count <= inflight_count + 1'b1;
      end else if (!alloc && match_any) begin
        inflight_count <= inflight_count - 1'b1;
      end
      for (int p = 0; p < NUM_REQ; p++) begin
        if (port_inc[p] && !port_dec[p]) begin
          port_cnt[p] <= port_cnt[p] + 1'b1;
        end else if (!port_inc[p] && port_dec[p]) begin
          port_cnt[p] <= port_cnt[p] - 1'b1;
        end
      end
    end
  end

  // Pointer moves just past the port that completed a handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (up_hs) begin
      rr_ptr <= (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Single-entry output register toward the wrapper, held under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_type  <= 1'b0;
      out_src       <= '0;
    end else if (up_hs) begin
      mem_req_valid <= 1'b1;
      mem_req_addr  <= grant_addr;
      mem_req_type  <= grant_type;
      out_src       <= grant_idx;
    end else if (mem_req_ready) begin
      mem_req_valid <= 1'b0;
    end
  end

  assign mem_req_source_id = 32'(out_src);

  // Registered response routing and sticky unmatched-response flag
  always_ff @(posedge clk) begin
    if (rst) begin
      up_resp_valid <= '0;
      up_resp_addr  <= '0;
      err_unmatched <= 1'b0;
    end else begin
      up_resp_valid <= match_any ? (NUM_REQ'(1) << match_src) : '0;
      if (match_any) begin
        up_resp_addr <= mem_resp_addr;
      end
      if (mem_resp_valid && !match_any) begin
        err_unmatched <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ramulator_req_arbiter.sv
// tb_ramulator_req_arbiter
// Directed bench for ramulator_req_arbiter: a vector table for the grant
// rotation plus hand-written sequences for table fill, per-port cap,
// address hazard, backpressure and unmatched responses.

module tb_ramulator_req_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 64;
  localparam int CNT_W   = 7;

  logic                      clk;
  logic                      rst;
  logic                      init_done;
  logic [NUM_REQ-1:0]        up_req_valid;
  logic [NUM_REQ*ADDR_W-1:0] up_req_addr;
  logic [NUM_REQ-1:0]        up_req_type;
  logic [NUM_REQ-1:0]        up_req_ready;
  logic [NUM_REQ-1:0]        up_resp_valid;
  logic [ADDR_W-1:0]         up_resp_addr;
  logic                      mem_req_valid;
  logic [ADDR_W-1:0]         mem_req_addr;
  logic                      mem_req_type;
  logic [31:0]               mem_req_source_id;
  logic                      mem_req_ready;
  logic                      mem_resp_valid;
  logic [ADDR_W-1:0]         mem_resp_addr;
  logic [CNT_W-1:0]          inflight_count;
  logic                      err_unmatched;

  int total;
  int bad;

  typedef struct {
    logic       init;
    logic [3:0] valid;
    logic [3:0] exp_ready;
    int         exp_src;
  } vec_t;

  vec_t vecs[9];

  ramulator_req_arbiter #(
    .NUM_REQ(4), .MAX_INFLIGHT(64), .PORT_MAX_INFLIGHT(16), .ADDR_W(64)
  ) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .up_req_valid(up_req_valid), .up_req_addr(up_req_addr), .up_req_type(up_req_type),
    .up_req_ready(up_req_ready), .up_resp_valid(up_resp_valid), .up_resp_addr(up_resp_addr),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_type(mem_req_type),
    .mem_req_source_id(mem_req_source_id), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_addr(mem_resp_addr),
    .inflight_count(inflight_count), .err_unmatched(err_unmatched)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic set_addr(input int port, input logic [63:0] a);
    up_req_addr[port*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic apply_stimulus(input logic init, input logic [3:0] valid);
    init_done    = init;
    up_req_valid = valid;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    init_done      = 1'b0;
    up_req_valid   = '0;
    up_req_addr    = '0;
    up_req_type    = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_addr  = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [63:0] addrs [3];
    int grants [4];
    int cap_grants;

    total = 0;
    bad   = 0;
    clk   = 1'b0;

    vecs[0] = '{init: 1'b0, valid: 4'b1111, exp_ready: 4'b0000, exp_src: 0};
    vecs[1] = '{init: 1'b1, valid: 4'b0000, exp_ready: 4'b0000, exp_src: 0};
    vecs[2] = '{init: 1'b1, valid: 4'b1010, exp_ready: 4'b0010, exp_src: 1};
    vecs[3] = '{init: 1'b1, valid: 4'b1010, exp_ready: 4'b1000, exp_src: 3};
    vecs[4] = '{init: 1'b1, valid: 4'b0001, exp_ready: 4'b0001, exp_src: 0};
    vecs[5] = '{init: 1'b1, valid: 4'b0101, exp_ready: 4'b0100, exp_src: 2};
    vecs[6] = '{init: 1'b1, valid: 4'b0011, exp_ready: 4'b0001, exp_src: 0};
    vecs[7] = '{init: 1'b1, valid: 4'b1111, exp_ready: 4'b0010, exp_src: 1};
    vecs[8] = '{init: 1'b1, valid: 4'b1001, exp_ready: 4'b1000, exp_src: 3};

    // Reset state
    do_reset();
    check_output("rst_ready", 64'(up_req_ready), 64'h0);
    check_output("rst_resp_valid", 64'(up_resp_valid), 64'h0);
    check_output("rst_mem_valid", 64'(mem_req_valid), 64'h0);
    check_output("rst_src", 64'(mem_req_source_id), 64'h0);
    check_output("rst_count", 64'(inflight_count), 64'h0);
    check_output("rst_err", 64'(err_unmatched), 64'h0);

    // Single requester: three reads then their responses
    addrs[0] = 64'h0;
    addrs[1] = 64'h40;
    addrs[2] = 64'h80;
    mem_req_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      set_addr(0, addrs[j]);
      apply_stimulus(1'b1, 4'b0001);
      #1;
      check_output("single_ready", 64'(up_req_ready), 64'h1);
      step();
      check_output("single_mem_valid", 64'(mem_req_valid), 64'h1);
      check_output("single_mem_addr", mem_req_addr, addrs[j]);
      check_output("single_src", 64'(mem_req_source_id), 64'h0);
      check_output("single_count", 64'(inflight_count), 64'(j + 1));
    end
    up_req_valid = '0;
    step();
    check_output("single_drain", 64'(mem_req_valid), 64'h0);
    for (int j = 0; j < 3; j++) begin
      mem_resp_valid = 1'b1;
      mem_resp_addr  = addrs[j];
      step();
      check_output("single_resp_valid", 64'(up_resp_valid), 64'h1);
      check_output("single_resp_addr", up_resp_addr, addrs[j]);
      check_output("single_resp_count", 64'(inflight_count), 64'(2 - j));
    end
    mem_resp_valid = 1'b0;
    step();
    check_output("single_resp_idle", 64'(up_resp_valid), 64'h0);
    check_output("single_err", 64'(err_unmatched), 64'h0);

    // Vector table: round-robin rotation over varying valid masks
    do_reset();
    mem_req_ready = 1'b1;
    for (int r = 0; r < 9; r++) begin
      for (int i = 0; i < 4; i++) set_addr(i, 64'h2000 + 64'((r * 4 + i) * 64));
      apply_stimulus(vecs[r].init, vecs[r].valid);
      #1;
      check_output($sformatf("vec%0d_ready", r), 64'(up_req_ready), 64'(vecs[r].exp_ready));
      step();
      if (vecs[r].exp_ready != 4'b0000) begin
        check_output($sformatf("vec%0d_mem_valid", r), 64'(mem_req_valid), 64'h1);
        check_output($sformatf("vec%0d_src", r), 64'(mem_req_source_id), 64'(vecs[r].exp_src));
      end else begin
        check_output($sformatf("vec%0d_mem_idle", r), 64'(mem_req_valid), 64'h0);
      end
    end

    // Four requesters all valid: fair rotation until the table is full
    do_reset();
    mem_req_ready = 1'b1;
    for (int p = 0; p < 4; p++) grants[p] = 0;
    for (int k = 0; k < 64; k++) begin
      for (int i = 0; i < 4; i++) set_addr(i, 64'h10000 + 64'((k * 4 + i) * 64));
      apply_stimulus(1'b1, 4'b1111);
      #1;
      check_output("rr_ready", 64'(up_req_ready), 64'(4'b0001 << (k % 4)));
      for (int p = 0; p < 4; p++) if (up_req_ready[p]) grants[p]++;
      step();
      check_output("rr_src", 64'(mem_req_source_id), 64'(k % 4));
    end
    check_output("full_count", 64'(inflight_count), 64'd64);
    for (int p = 0; p < 4; p++) check_output($sformatf("rr_share%0d", p), 64'(grants[p]), 64'd16);
    for (int i = 0; i < 4; i++) set_addr(i, 64'h10000 + 64'((64 * 4 + i) * 64));
    #1;
    check_output("full_ready", 64'(up_req_ready), 64'h0);
    step();
    mem_resp_valid = 1'b1;
    mem_resp_addr  = 64'h10000;
    #1;
    check_output("full_free_cycle_ready", 64'(up_req_ready), 64'h0);
    step();
    mem_resp_valid = 1'b0;
    check_output("full_resp_valid", 64'(up_resp_valid), 64'h1);
    check_output("full_count_after_free", 64'(inflight_count), 64'd63);
    #1;
    check_output("full_regrant", 64'(up_req_ready), 64'h1);
    step();
    check_output("full_refill_count", 64'(inflight_count), 64'd64);
    up_req_valid = '0;

    // Port 0 alone stalls at its outstanding cap
    do_reset();
    mem_req_ready = 1'b1;
    cap_grants = 0;
    for (int k = 0; k < 20; k++) begin
      set_addr(0, 64'h30000 + 64'(k * 64));
      apply_stimulus(1'b1, 4'b0001);
      #1;
      check_output("cap_ready", 64'(up_req_ready), (k < 16) ? 64'h1 : 64'h0);
      if (up_req_ready[0]) cap_grants++;
      step();
    end
    check_output("cap_grants", 64'(cap_grants), 64'd16);
    check_output("cap_count", 64'(inflight_count), 64'd16);
    mem_resp_valid = 1'b1;
    mem_resp_addr  = 64'h30000;
    #1;
    check_output("cap_free_cycle_ready", 64'(up_req_ready), 64'h0);
    step();
    mem_resp_valid = 1'b0;
    check_output("cap_resp_valid", 64'(up_resp_valid), 64'h1);
    #1;
    check_output("cap_regrant", 64'(up_req_ready), 64'h1);
    step();
    check_output("cap_count_after", 64'(inflight_count), 64'd16);
    up_req_valid = '0;

    // Address hazard between requesters 1 and 2
    do_reset();
    mem_req_ready = 1'b1;
    set_addr(1, 64'h100);
    apply_stimulus(1'b1, 4'b0010);
    #1;
    check_output("haz_first_ready", 64'(up_req_ready), 64'h2);
    step();
    set_addr(2, 64'h100);
    apply_stimulus(1'b1, 4'b0100);
    for (int k = 0; k < 3; k++) begin
      #1;
      check_output("haz_blocked", 64'(up_req_ready), 64'h0);
      step();
    end
    mem_resp_valid = 1'b1;
    mem_resp_addr  = 64'h100;
    #1;
    check_output("haz_free_cycle_blocked", 64'(up_req_ready), 64'h0);
    step();
    mem_resp_valid = 1'b0;
    check_output("haz_resp_valid", 64'(up_resp_valid), 64'h2);
    check_output("haz_resp_addr", up_resp_addr, 64'h100);
    #1;
    check_output("haz_grant", 64'(up_req_ready), 64'h4);
    step();
    check_output("haz_src", 64'(mem_req_source_id), 64'h2);
    check_output("haz_addr", mem_req_addr, 64'h100);
    up_req_valid = '0;

    // Output-stage backpressure holds the request and blocks new grants
    do_reset();
    mem_req_ready = 1'b0;
    set_addr(3, 64'h500);
    up_req_type = 4'b1000;
    apply_stimulus(1'b1, 4'b1000);
    #1;
    check_output("bp_first_ready", 64'(up_req_ready), 64'h8);
    step();
    set_addr(0, 64'h600);
    up_req_type = 4'b0000;
    apply_stimulus(1'b1, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      #1;
      check_output("bp_ready", 64'(up_req_ready), 64'h0);
      check_output("bp_valid", 64'(mem_req_valid), 64'h1);
      check_output("bp_addr", mem_req_addr, 64'h500);
      check_output("bp_type", 64'(mem_req_type), 64'h1);
      check_output("bp_src", 64'(mem_req_source_id), 64'h3);
      step();
    end
    mem_req_ready = 1'b1;
    #1;
    check_output("bp_release_ready", 64'(up_req_ready), 64'h1);
    step();
    check_output("bp_next_addr", mem_req_addr, 64'h600);
    check_output("bp_next_src", 64'(mem_req_source_id), 64'h0);
    check_output("bp_next_type", 64'(mem_req_type), 64'h0);
    up_req_valid = '0;
    step();
    check_output("bp_drain", 64'(mem_req_valid), 64'h0);
    check_output("bp_count", 64'(inflight_count), 64'd2);

    // Unmatched response sets a sticky error; reset clears everything
    mem_resp_valid = 1'b1;
    mem_resp_addr  = 64'hDEAD_0000;
    step();
    mem_resp_valid = 1'b0;
    check_output("unm_resp_valid", 64'(up_resp_valid), 64'h0);
    check_output("unm_err", 64'(err_unmatched), 64'h1);
    check_output("unm_count", 64'(inflight_count), 64'd2);
    step();
    step();
    step();
    check_output("unm_err_sticky", 64'(err_unmatched), 64'h1);
    do_reset();
    check_output("unm_rst_err", 64'(err_unmatched), 64'h0);
    check_output("unm_rst_count", 64'(inflight_count), 64'h0);
    check_output("unm_rst_mem_valid", 64'(mem_req_valid), 64'h0);
    mem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_addr(i, 64'h600 + 64'(i * 64));
    apply_stimulus(1'b1, 4'b1111);
    #1;
    check_output("unm_rst_ptr", 64'(up_req_ready), 64'h1);
    step();
    up_req_valid = '0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
